// File: rtl/mem_port_arbiter.sv
// Arbitrates the single memory adaptor between icache fetch and LSU data ports.
// Ports: clk_in/rst_in/rdy_in, flush_pipline, ins_* fetch port, data_* LSU port, mem_* adaptor port.
module mem_port_arbiter #(
  parameter int STARVE_LIMIT = 4,
  parameter int CNT_W        = 3
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  input  logic        flush_pipline,
  input  logic        ins_req,
  input  logic [31:0] ins_addr,
  output logic [31:0] ins_data,
  output logic        ins_done,
  input  logic        data_req,
  input  logic [31:0] data_addr,
  input  logic        data_is_write,
  input  logic [1:0]  data_width,
  input  logic [31:0] data_wdata,
  output logic [31:0] data_rdata,
  output logic        data_done,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  output logic        mem_is_write,
  output logic [1:0]  mem_width,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_done
);

  typedef enum logic [1:0] {
    IDLE,
    BUSY_INS,
    BUSY_DATA,
    DRAIN
  } state_t;

  localparam logic [CNT_W-1:0] LIMIT   = CNT_W'(STARVE_LIMIT);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] cnt;

  logic ins_eff;
  logic data_eff;
  logic ins_wins;
  logic grant_i;
  logic grant_d;
  logic fin_i;
  logic fin_d;

  // A request whose done pulse is showing is the one just served;
  // masking it stops an immediate re-grant of the same transaction.
  always_comb begin
    ins_eff  = ins_req & ~ins_done;
    data_eff = data_req & ~data_done;
    ins_wins = ins_eff & ~flush_pipline &
               (~data_eff | (cnt >= LIMIT));
    grant_i   = 1'b0;
    grant_d   = 1'b0;
    fin_i     = 1'b0;
    fin_d     = 1'b0;
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (ins_wins) begin
          grant_i   = 1'b1;
          state_nxt = BUSY_INS;
        end else if (data_eff) begin
          grant_d   = 1'b1;
          state_nxt = BUSY_DATA;
        end
      end
      BUSY_DATA: begin
        if (mem_done) begin
          fin_d     = 1'b1;
          state_nxt = IDLE;
        end
      end
      BUSY_INS: begin
        if (mem_done) begin
          fin_i     = ~flush_pipline;
          state_nxt = IDLE;
        end else if (flush_pipline) begin
          state_nxt = DRAIN;
        end
      end
      DRAIN: begin
        if (mem_done) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state <= IDLE;
    end else if (rdy_in) begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      mem_req      <= 1'b0;
      mem_addr     <= '0;
      mem_is_write <= 1'b0;
      mem_width    <= '0;
      mem_wdata    <= '0;
      ins_done     <= 1'b0;
      data_done    <= 1'b0;
      ins_data     <= '0;
      data_rdata   <= '0;
      cnt          <= '0;
    end else if (rdy_in) begin
      ins_done  <= fin_i;
      data_done <= fin_d;
      if (fin_i) ins_data <= mem_rdata;
      if (fin_d) data_rdata <= mem_is_write ? '0 : mem_rdata;
      if (grant_i) begin
        mem_req      <= 1'b1;
        mem_addr     <= ins_addr;
        mem_is_write <= 1'b0;
        mem_width    <= 2'd2;
        mem_wdata    <= '0;
        cnt          <= '0;
      end else if (grant_d) begin
        mem_req      <= 1'b1;
        mem_addr     <= data_addr;
        mem_is_write <= data_is_write;
        mem_width    <= data_width;
        mem_wdata    <= data_wdata;
        // Count only data grants that jump ahead of a waiting fetch.
        if (!ins_eff) cnt <= '0;
        else if (cnt != CNT_MAX) cnt <= cnt + 1'b1;
      end else if (mem_done && state != IDLE) begin
        mem_req <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter.
// Directed stimulus; a negedge monitor checks grants and done pulses.
module tb_mem_port_arbiter;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic        rdy_in;
  logic        flush_pipline;
  logic        ins_req;
  logic [31:0] ins_addr;
  logic [31:0] ins_data;
  logic        ins_done;
  logic        data_req;
  logic [31:0] data_addr;
  logic        data_is_write;
  logic [1:0]  data_width;
  logic [31:0] data_wdata;
  logic [31:0] data_rdata;
  logic        data_done;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_is_write;
  logic [1:0]  mem_width;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_done;

  mem_port_arbiter #(.STARVE_LIMIT(4), .CNT_W(3)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
    .flush_pipline(flush_pipline),
    .ins_req(ins_req), .ins_addr(ins_addr),
    .ins_data(ins_data), .ins_done(ins_done),
    .data_req(data_req), .data_addr(data_addr),
    .data_is_write(data_is_write), .data_width(data_width),
    .data_wdata(data_wdata), .data_rdata(data_rdata),
    .data_done(data_done),
    .mem_req(mem_req), .mem_addr(mem_addr),
    .mem_is_write(mem_is_write), .mem_width(mem_width),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .mem_done(mem_done)
  );

  always #5 clk_in = ~clk_in;

  typedef struct {
    logic [31:0] addr;
    logic [1:0]  width;
    logic        wr;
    logic [31:0] wdata;
  } grant_t;

  grant_t      exp_grant[$];
  logic [31:0] exp_ins[$];
  logic [31:0] exp_data[$];
  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk_in);
    #1;
  endtask

  task automatic push_g(input logic [31:0] a, input logic [1:0] w,
                        input logic wr, input logic [31:0] wd);
    grant_t g;
    g.addr = a; g.width = w; g.wr = wr; g.wdata = wd;
    exp_grant.push_back(g);
  endtask

  logic prev_req = 1'b0;

  always @(negedge clk_in) begin
    grant_t g;
    logic [31:0] e;
    if (mem_req === 1'b1 && prev_req !== 1'b1) begin
      if (exp_grant.size() == 0) begin
        tests++; fails++;
        $display("FAIL grant_unexpected: addr %h", mem_addr);
      end else begin
        g = exp_grant.pop_front();
        chk("grant_addr", mem_addr, g.addr);
        chk("grant_width", 32'(mem_width), 32'(g.width));
        chk("grant_wr", 32'(mem_is_write), 32'(g.wr));
        if (g.wr) chk("grant_wdata", mem_wdata, g.wdata);
      end
    end
    prev_req = mem_req;
    if (ins_done === 1'b1) begin
      if (exp_ins.size() == 0) begin
        tests++; fails++;
        $display("FAIL ins_done_unexpected: data %h", ins_data);
      end else begin
        e = exp_ins.pop_front();
        chk("ins_data", ins_data, e);
      end
    end
    if (data_done === 1'b1) begin
      if (exp_data.size() == 0) begin
        tests++; fails++;
        $display("FAIL data_done_unexpected: data %h", data_rdata);
      end else begin
        e = exp_data.pop_front();
        chk("data_rdata", data_rdata, e);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int nd;
    int cyc;
    rst_in = 1; rdy_in = 1; flush_pipline = 0;
    ins_req = 0; ins_addr = 0;
    data_req = 0; data_addr = 0; data_is_write = 0;
    data_width = 0; data_wdata = 0;
    mem_rdata = 0; mem_done = 0;
    tick; tick;
    chk("rst_mem_req", 32'(mem_req), 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_done", {30'd0, ins_done, data_done}, 0);
    chk("rst_rdata", ins_data | data_rdata, 0);
    rst_in = 0;

    // Uncontended fetch, mem_done three cycles after the request edge.
    tick;
    ins_req = 1; ins_addr = 32'h1000;
    push_g(32'h1000, 2'd2, 1'b0, 32'h0);
    exp_ins.push_back(32'h13);
    tick;
    chk("t1_req_T1", 32'(mem_req), 1);
    tick; tick;
    mem_done = 1; mem_rdata = 32'h13;
    chk("t1_req_T3", 32'(mem_req), 1);
    tick;
    mem_done = 0; ins_req = 0;
    chk("t1_req_T4", 32'(mem_req), 0);
    chk("t1_done_T4", 32'(ins_done), 1);
    tick;
    chk("t1_done_T5", 32'(ins_done), 0);

    // Starvation guard: flush in each data_done cycle keeps data eligible.
    data_req = 1; data_addr = 32'h20000; data_is_write = 1;
    data_width = 0; data_wdata = 32'hAB;
    ins_req = 1; ins_addr = 32'h1000; mem_rdata = 32'h13;
    for (int i = 0; i < 4; i++) begin
      push_g(32'h20000, 2'd0, 1'b1, 32'hAB);
      exp_data.push_back(32'h0);
    end
    push_g(32'h1000, 2'd2, 1'b0, 32'h0);
    exp_ins.push_back(32'h13);
    push_g(32'h20000, 2'd0, 1'b1, 32'hAB);
    exp_data.push_back(32'h0);
    nd = 0; cyc = 0;
    while (nd < 5 && cyc < 60) begin
      tick; cyc++;
      mem_done = mem_req && !mem_done;
      flush_pipline = data_done;
      if (ins_done) ins_req = 0;
      if (data_done) begin
        nd++;
        if (nd == 5) data_req = 0;
      end
    end
    chk("t2_data_dones", nd, 5);
    flush_pipline = 0; mem_done = 0; data_is_write = 0;
    tick;

    // Flush one cycle before mem_done: drain, then new fetch.
    ins_req = 1; ins_addr = 32'h3000;
    push_g(32'h3000, 2'd2, 1'b0, 32'h0);
    tick;
    tick;
    flush_pipline = 1;
    tick;
    flush_pipline = 0;
    chk("t3_drain_req", 32'(mem_req), 1);
    ins_addr = 32'h2000;
    mem_done = 1; mem_rdata = 32'hDEAD;
    push_g(32'h2000, 2'd2, 1'b0, 32'h0);
    exp_ins.push_back(32'h55);
    tick;
    mem_done = 0;
    chk("t3_no_done", 32'(ins_done), 0);
    chk("t3_req_drop", 32'(mem_req), 0);
    chk("t3_ins_data_kept", ins_data, 32'h13);
    tick;
    chk("t3_new_grant", mem_addr, 32'h2000);
    mem_done = 1; mem_rdata = 32'h55;
    tick;
    mem_done = 0; ins_req = 0;
    tick;

    // Flush on the request cycle blocks the grant for one cycle.
    ins_req = 1; ins_addr = 32'h4000; flush_pipline = 1;
    push_g(32'h4000, 2'd2, 1'b0, 32'h0);
    exp_ins.push_back(32'h44);
    tick;
    flush_pipline = 0;
    chk("t4_no_grant", 32'(mem_req), 0);
    tick;
    chk("t4_grant", 32'(mem_req), 1);
    mem_done = 1; mem_rdata = 32'h44;
    tick;
    mem_done = 0; ins_req = 0;
    tick;

    // Load with a flush in flight completes normally.
    data_req = 1; data_addr = 32'h30004; data_is_write = 0;
    data_width = 1; data_wdata = 0;
    push_g(32'h30004, 2'd1, 1'b0, 32'h0);
    exp_data.push_back(32'hBEEF);
    tick;
    flush_pipline = 1;
    tick;
    flush_pipline = 0;
    mem_done = 1; mem_rdata = 32'h0000BEEF;
    tick;
    mem_done = 0; data_req = 0;
    chk("t5_done", 32'(data_done), 1);
    tick;

    // rdy_in low for three cycles with a spurious mem_done.
    data_req = 1; data_addr = 32'h40008; data_width = 2;
    push_g(32'h40008, 2'd2, 1'b0, 32'h0);
    exp_data.push_back(32'h1234);
    tick;
    rdy_in = 0; mem_done = 1; mem_rdata = 32'h9999;
    tick;
    mem_done = 0;
    tick; tick;
    chk("t6_frozen_req", 32'(mem_req), 1);
    chk("t6_frozen_done", 32'(data_done), 0);
    rdy_in = 1;
    tick;
    chk("t6_still_busy", 32'(mem_req), 1);
    mem_done = 1; mem_rdata = 32'h1234;
    tick;
    mem_done = 0; data_req = 0;
    chk("t6_done", 32'(data_done), 1);
    tick;

    // Synchronous reset mid-fetch.
    ins_req = 1; ins_addr = 32'h5000;
    push_g(32'h5000, 2'd2, 1'b0, 32'h0);
    tick;
    rst_in = 1; ins_req = 0;
    tick;
    rst_in = 0;
    chk("t7_req", 32'(mem_req), 0);
    chk("t7_addr", mem_addr, 0);
    chk("t7_width", 32'(mem_width), 0);
    chk("t7_rdata", ins_data | data_rdata, 0);
    mem_done = 1; mem_rdata = 32'h77;
    tick;
    mem_done = 0;
    chk("t7_idle_no_done", 32'(ins_done), 0);
    tick; tick;

    chk("q_grant_empty", exp_grant.size(), 0);
    chk("q_ins_empty", exp_ins.size(), 0);
    chk("q_data_empty", exp_data.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
